mem_port_arbiter: RTL

- Shares the core's single memory port between the instruction-fetch requester (read-only) and the load/store data requester (read/write).
- Supports one outstanding transaction at a time.
- Data side has priority. A streak counter guarantees that instruction fetch cannot be starved.
- Sits between the fetch/LSU logic and the unified memory, and sequences every access as grant → issue → response.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (read-only) and LSU (read/write); data wins, streak counter stops fetch starvation.
// Latency: gnt in cycle 0, mem_req from cycle 1, rvalid at best in cycle 3; one transaction outstanding at a time.
// Backpressure: mem_gnt low holds the request in ISSUE, gnts stay low while busy; `MEM_ARB_TIMEOUT_EN adds a response watchdog.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_t        state;
  logic [SW-1:0] streak;
  logic          owner_d;
  logic          d_win;
  logic          i_win;
  logic          timeout_fire;

  // Fetch is forced only once the data side has won MAX_D_STREAK times while fetch waited.
  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    if (reset && state == IDLE) begin
      if (d_req && !(i_req && streak == STREAK_MAX))
        d_win = 1'b1;
      else if (i_req)
        i_win = 1'b1;
    end
  end

  assign d_gnt = d_win;
  assign i_gnt = i_win;
  assign busy  = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wdog;

  // A real response arriving on the last allowed cycle still wins over the timeout.
  assign timeout_fire = (state != IDLE) && (wdog == WW'(TIMEOUT_CYCLES - 1)) &&
                        !(state == WAIT && mem_rvalid);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wdog  <= '0;
      i_err <= 1'b0;
      d_err <= 1'b0;
    end else begin
      wdog  <= (state == IDLE || timeout_fire) ? '0 : wdog + WW'(1);
      i_err <= timeout_fire && !owner_d;
      d_err <= timeout_fire && owner_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign i_err        = 1'b0;
  assign d_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      owner_d   <= 1'b0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (timeout_fire) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        if (owner_d) begin
          d_rvalid <= 1'b1;
          d_rdata  <= '0;
        end else begin
          i_rvalid <= 1'b1;
          i_rdata  <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (d_win) begin
              state     <= ISSUE;
              owner_d   <= 1'b1;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (!i_req)
                streak <= '0;
              else if (streak != STREAK_MAX)
                streak <= streak + SW'(1);
            end else if (i_win) begin
              state     <= ISSUE;
              owner_d   <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_be    <= 4'hF;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              streak    <= '0;
            end
          end
          ISSUE: begin
            if (mem_gnt) begin
              mem_req <= 1'b0;
              state   <= WAIT;
            end
          end
          WAIT: begin
            if (mem_rvalid) begin
              state <= IDLE;
              if (owner_d) begin
                d_rvalid <= 1'b1;
                if (!mem_we)
                  d_rdata <= mem_rdata;
              end else begin
                i_rvalid <= 1'b1;
                i_rdata  <= mem_rdata;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
